// File: rtl/vga_timing_detect_if.sv
// Video input and measurement result bundle for vga_timing_detect.
// master drives the video inputs; slave is the detector side.
`timescale 1ns/1ps
interface vga_timing_detect_if;
    logic        hsync_in;
    logic        vsync_in;
    logic        de_in;
    logic        de;
    logic [9:0]  sx;
    logic [9:0]  sy;
    logic        frame;
    logic        locked;
    logic        mode_ok;
    logic [10:0] h_total;
    logic [10:0] h_active;
    logic [9:0]  v_total;
    logic [9:0]  v_active;

    modport master (
        output hsync_in, vsync_in, de_in,
        input  de, sx, sy, frame, locked, mode_ok, h_total, h_active, v_total, v_active
    );

    modport slave (
        input  hsync_in, vsync_in, de_in,
        output de, sx, sy, frame, locked, mode_ok, h_total, h_active, v_total, v_active
    );
endinterface

// File: rtl/vga_timing_detect.sv
// Receive-side VGA timing detector: measures line/frame geometry, recovers sx/sy, reports lock.
// Optional macro VGA_TDET_AUTOPOL_EN enables per-signal sync polarity detection (default: active-low).
`timescale 1ns/1ps
module vga_timing_detect #(
    parameter int LOCK_FRAMES  = 2,
    parameter int H_TOTAL_EXP  = 1056,
    parameter int H_ACTIVE_EXP = 800,
    parameter int V_TOTAL_EXP  = 628,
    parameter int V_ACTIVE_EXP = 600
) (
    input logic               clk_pix,
    input logic               rst_pix,
    vga_timing_detect_if.slave vid
);
    typedef enum logic [1:0] {SEARCH, MEASURE, CHECK, LOCKED} state_t;

    state_t      state;
    logic [3:0]  match_cnt;
    logic        locked_r;
    logic        hs_q, hs_qq, vs_q, vs_qq, de_q, de_qq;
    logic        hs_act_q, hs_act_qq, vs_act_q, vs_act_qq;
    logic [10:0] hcnt, rcnt, hl_len, ar_len;
    logic        hl_valid, ar_valid, frame_bad;
    logic [9:0]  lcnt, acnt;
    logic [9:0]  sx_r, sy_r;
    logic [10:0] h_total_r, h_active_r;
    logic [9:0]  v_total_r, v_active_r;

`ifdef VGA_TDET_AUTOPOL_EN
    // Idle levels are sampled while de rises, i.e. well outside any sync pulse.
    logic hs_idle, vs_idle;
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            hs_idle <= 1'b1;
            vs_idle <= 1'b1;
        end else if (de_q && !de_qq) begin
            hs_idle <= hs_q;
            vs_idle <= vs_q;
        end
    end
    assign hs_act_q  = hs_q  ^ hs_idle;
    assign hs_act_qq = hs_qq ^ hs_idle;
    assign vs_act_q  = vs_q  ^ vs_idle;
    assign vs_act_qq = vs_qq ^ vs_idle;
`else
    assign hs_act_q  = ~hs_q;
    assign hs_act_qq = ~hs_qq;
    assign vs_act_q  = ~vs_q;
    assign vs_act_qq = ~vs_qq;
`endif

    logic h_edge, v_edge, de_rise, de_fall;
    assign h_edge  = hs_act_q & ~hs_act_qq;
    assign v_edge  = vs_act_q & ~vs_act_qq;
    assign de_rise = de_q & ~de_qq;
    assign de_fall = ~de_q & de_qq;

    logic [10:0] line_len, run_len, ht_fin, ha_fin;
    logic [9:0]  vt_fin, va_fin;
    logic        line_bad, run_bad, bad_fin, timeout, match, store;

    assign line_len = (hcnt == '1) ? hcnt : hcnt + 11'd1;
    assign run_len  = (rcnt == '1) ? rcnt : rcnt + 11'd1;
    assign line_bad = h_edge && hl_valid && (line_len != hl_len);
    assign run_bad  = de_fall && ar_valid && (run_len != ar_len);

    // Frame totals including any event landing on the vsync edge cycle itself.
    assign ht_fin  = (h_edge && !hl_valid) ? line_len : hl_len;
    assign ha_fin  = (de_fall && !ar_valid) ? run_len : ar_len;
    assign vt_fin  = (h_edge && lcnt != '1) ? lcnt + 10'd1 : lcnt;
    assign va_fin  = (de_fall && acnt != '1) ? acnt + 10'd1 : acnt;
    assign bad_fin = frame_bad | line_bad | run_bad;
    assign timeout = (hcnt == '1) || (lcnt == '1);
    assign match   = !bad_fin && (ht_fin == h_total_r) && (ha_fin == h_active_r) &&
                     (vt_fin == v_total_r) && (va_fin == v_active_r);
    assign store   = v_edge && !timeout &&
                     ((state == MEASURE) || (state == CHECK && !match) || (state == LOCKED && !match));

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            hs_q <= 1'b0;  hs_qq <= 1'b0;
            vs_q <= 1'b0;  vs_qq <= 1'b0;
            de_q <= 1'b0;  de_qq <= 1'b0;
            hcnt <= '0;    rcnt <= '0;
            lcnt <= '0;    acnt <= '0;
            hl_len <= '0;  hl_valid <= 1'b0;
            ar_len <= '0;  ar_valid <= 1'b0;
            frame_bad <= 1'b0;
            sx_r <= '0;    sy_r <= '0;
        end else begin
            hs_q <= vid.hsync_in;  hs_qq <= hs_q;
            vs_q <= vid.vsync_in;  vs_qq <= vs_q;
            de_q <= vid.de_in;     de_qq <= de_q;
            hcnt <= h_edge ? '0 : line_len;
            rcnt <= de_qq ? run_len : '0;
            if (v_edge) begin
                lcnt      <= '0;
                acnt      <= '0;
                hl_valid  <= 1'b0;
                ar_valid  <= 1'b0;
                frame_bad <= 1'b0;
            end else begin
                lcnt <= vt_fin;
                acnt <= va_fin;
                if (h_edge && !hl_valid) begin
                    hl_len   <= line_len;
                    hl_valid <= 1'b1;
                end
                if (de_fall && !ar_valid) begin
                    ar_len   <= run_len;
                    ar_valid <= 1'b1;
                end
                if (line_bad || run_bad)
                    frame_bad <= 1'b1;
            end
            if (de_rise)
                sx_r <= '0;
            else if (de_q && de_qq && sx_r != '1)
                sx_r <= sx_r + 10'd1;
            if (v_edge)
                sy_r <= '0;
            else if (de_fall && sy_r != '1)
                sy_r <= sy_r + 10'd1;
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            h_total_r  <= '0;
            h_active_r <= '0;
            v_total_r  <= '0;
            v_active_r <= '0;
        end else if (store) begin
            h_total_r  <= ht_fin;
            h_active_r <= ha_fin;
            v_total_r  <= vt_fin;
            v_active_r <= va_fin;
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            state     <= SEARCH;
            match_cnt <= '0;
            locked_r  <= 1'b0;
        end else if (timeout) begin
            state     <= SEARCH;
            match_cnt <= '0;
            locked_r  <= 1'b0;
        end else if (v_edge) begin
            case (state)
                SEARCH:  state <= MEASURE;
                MEASURE: begin
                    match_cnt <= '0;
                    state     <= CHECK;
                end
                CHECK: begin
                    if (match) begin
                        match_cnt <= match_cnt + 4'd1;
                        if (int'(match_cnt) + 1 >= LOCK_FRAMES) begin
                            state    <= LOCKED;
                            locked_r <= 1'b1;
                        end
                    end else begin
                        match_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (!match) begin
                        match_cnt <= '0;
                        state     <= CHECK;
                        locked_r  <= 1'b0;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

    assign vid.de       = de_qq;
    assign vid.sx       = sx_r;
    assign vid.sy       = sy_r;
    assign vid.frame    = v_edge;
    assign vid.locked   = locked_r;
    assign vid.h_total  = h_total_r;
    assign vid.h_active = h_active_r;
    assign vid.v_total  = v_total_r;
    assign vid.v_active = v_active_r;
    assign vid.mode_ok  = locked_r &&
                          (h_total_r  == 11'(H_TOTAL_EXP))  && (h_active_r == 11'(H_ACTIVE_EXP)) &&
                          (v_total_r  == 10'(V_TOTAL_EXP))  && (v_active_r == 10'(V_ACTIVE_EXP));
endmodule

// File: tb/tb_vga_timing_detect.sv
// Directed bench for vga_timing_detect on a scaled-down raster (26x12 total, 16x6 active)
// so that every lock/timeout/reset sequence completes in a few thousand cycles.
`timescale 1ns/1ps
module tb_vga_timing_detect;
    localparam int HT = 26, HA = 16, HS0 = 18, HS1 = 22;
    localparam int VT = 12, VA = 6,  VS0 = 7,  VS1 = 9;
    localparam int SHORT_LINE = 9, SHORT_LEN = 20;

    logic clk_pix = 1'b0;
    logic rst_pix = 1'b1;
    vga_timing_detect_if vif();

    vga_timing_detect #(
        .LOCK_FRAMES(2), .H_TOTAL_EXP(HT), .H_ACTIVE_EXP(HA),
        .V_TOTAL_EXP(VT), .V_ACTIVE_EXP(VA)
    ) dut (
        .clk_pix(clk_pix),
        .rst_pix(rst_pix),
        .vid(vif)
    );

    always #5 clk_pix = ~clk_pix;

    int n_tests = 0;
    int n_fail  = 0;
    int gen_h = 0, gen_v = 0;
    bit gen_hold = 1'b0, inv_pol = 1'b0, short_req = 1'b0;

    // Raster source: drives a new pixel just after each rising edge.
    initial begin
        int hc, vc, len;
        bit hs, vs;
        hc = 0; vc = 0;
        vif.hsync_in = 1'b1; vif.vsync_in = 1'b1; vif.de_in = 1'b0;
        forever begin
            @(posedge clk_pix); #1;
            if (!gen_hold) begin
                hs = !(hc >= HS0 && hc < HS1);
                vs = !(vc >= VS0 && vc < VS1);
                vif.hsync_in = hs ^ inv_pol;
                vif.vsync_in = vs ^ inv_pol;
                vif.de_in    = (hc < HA) && (vc < VA);
                gen_h = hc; gen_v = vc;
                len = (short_req && vc == SHORT_LINE) ? SHORT_LEN : HT;
                if (hc == len - 1) begin
                    hc = 0;
                    vc = (vc == VT - 1) ? 0 : vc + 1;
                end else begin
                    hc = hc + 1;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_pulse(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk_pix);
            n++;
        end while (vif.frame !== 1'b1 && n < 1000);
        if (vif.frame !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL %s: got no frame pulse in 1000 cycles, expected one", name);
        end
    endtask

    task automatic wait_pos(input int v, input int h);
        int n;
        n = 0;
        do begin
            @(negedge clk_pix);
            n++;
        end while (!(gen_v == v && gen_h == h) && n < 400);
        if (!(gen_v == v && gen_h == h)) begin
            n_tests++; n_fail++;
            $display("FAIL wait_pos: got no position %0d/%0d in 400 cycles, expected it", v, h);
        end
    endtask

    // Four frame pulses from a cold start: lock appears one cycle after the fourth.
    task automatic relock_check(input string tag, input int first_v);
        wait_pulse({tag, "_p1"});
        check({tag, "_p1_line"}, gen_v, first_v);
        check({tag, "_p1_pix"}, gen_h, 1);
        wait_pulse({tag, "_p2"});
        wait_pulse({tag, "_p3"});
        @(negedge clk_pix);
        check({tag, "_locked_after_p3"}, vif.locked, 0);
        wait_pulse({tag, "_p4"});
        check({tag, "_locked_at_p4"}, vif.locked, 0);
        @(negedge clk_pix);
        check({tag, "_locked"}, vif.locked, 1);
        check({tag, "_mode_ok"}, vif.mode_ok, 1);
        check({tag, "_h_total"}, vif.h_total, HT);
        check({tag, "_h_active"}, vif.h_active, HA);
        check({tag, "_v_total"}, vif.v_total, VT);
        check({tag, "_v_active"}, vif.v_active, VA);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"}, vif.locked, 0);
        check({tag, "_mode_ok"}, vif.mode_ok, 0);
        check({tag, "_h_total"}, vif.h_total, 0);
        check({tag, "_h_active"}, vif.h_active, 0);
        check({tag, "_v_total"}, vif.v_total, 0);
        check({tag, "_v_active"}, vif.v_active, 0);
        check({tag, "_sx"}, vif.sx, 0);
        check({tag, "_sy"}, vif.sy, 0);
        check({tag, "_de"}, vif.de, 0);
        check({tag, "_frame"}, vif.frame, 0);
    endtask

    typedef struct {
        int v;
        int h;
        int de;
        int sx;
        int sy;
    } vec_t;

    initial begin
        vec_t vecs[9];
        vecs[0] = '{0, 0,  1, 0,  0};
        vecs[1] = '{2, 0,  1, 0,  2};
        vecs[2] = '{2, 7,  1, 7,  2};
        vecs[3] = '{2, 15, 1, 15, 2};
        vecs[4] = '{2, 16, 0, 15, 3};
        vecs[5] = '{4, 1,  1, 1,  4};
        vecs[6] = '{5, 15, 1, 15, 5};
        vecs[7] = '{6, 0,  0, 15, 6};
        vecs[8] = '{9, 5,  0, 15, 0};

        repeat (3) @(negedge clk_pix);
        check_all_zero("reset");
        rst_pix = 1'b0;

        relock_check("lock", VS0);

        for (int i = 0; i < 9; i++) begin
            wait_pos(vecs[i].v, vecs[i].h);
            repeat (2) @(negedge clk_pix);
            check($sformatf("vec%0d_de", i), vif.de, vecs[i].de);
            check($sformatf("vec%0d_sx", i), vif.sx, vecs[i].sx);
            check($sformatf("vec%0d_sy", i), vif.sy, vecs[i].sy);
        end

        // One short blanking line inside a frame while locked.
        wait_pulse("short_arm");
        short_req = 1'b1;
        wait_pulse("short_end");
        check("short_locked_at_pulse", vif.locked, 1);
        short_req = 1'b0;
        @(negedge clk_pix);
        check("short_locked_drop", vif.locked, 0);
        check("short_mode_ok_drop", vif.mode_ok, 0);
        check("short_h_total_kept", vif.h_total, HT);
        wait_pulse("short_clean1");
        @(negedge clk_pix);
        check("short_locked_after_clean1", vif.locked, 0);
        wait_pulse("short_clean2");
        @(negedge clk_pix);
        check("short_relocked", vif.locked, 1);
        check("short_mode_ok", vif.mode_ok, 1);

        // Freeze the raster so no hsync edge arrives.
        wait_pulse("freeze");
        gen_hold = 1'b1;
        repeat (2000) @(negedge clk_pix);
        check("timeout_locked_before", vif.locked, 1);
        repeat (100) @(negedge clk_pix);
        check("timeout_locked", vif.locked, 0);
        check("timeout_mode_ok", vif.mode_ok, 0);
        gen_hold = 1'b0;
        relock_check("after_timeout", VS0);

        // Asynchronous reset in the middle of an active line.
        wait_pos(3, 5);
        check("rst_locked_before", vif.locked, 1);
        #2;
        rst_pix = 1'b1;
        #1;
        check_all_zero("midrst");
        wait_pos(3, 15);
        rst_pix = 1'b0;
        relock_check("after_rst", VS0);

        // Inverted (active-high) syncs from a fresh reset.
        wait_pos(1, 10);
        rst_pix = 1'b1;
        inv_pol = 1'b1;
        wait_pos(1, 20);
        rst_pix = 1'b0;
`ifdef VGA_TDET_AUTOPOL_EN
        relock_check("invpol", VS0);
`else
        wait_pulse("invpol_p1");
        check("invpol_p1_line", gen_v, VS1);
        check("invpol_p1_pix", gen_h, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
